// File: rtl/shadow_dump_collector.sv
// shadow_dump_collector: sequences chain dumps, packs serial bits into words and queues them with per-chain trailers
module shadow_dump_collector #(
    parameter int NUM_CHAINS = 4,
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  sh_clk,
    input  logic                  sh_rst_l,
    input  logic                  start,
    output logic [NUM_CHAINS-1:0] dump_en,
    input  logic [NUM_CHAINS-1:0] ch_in,
    input  logic [NUM_CHAINS-1:0] ch_in_vld,
    input  logic [NUM_CHAINS-1:0] ch_in_done,
    output logic [WORD_W-1:0]     out_data,
    output logic                  out_last,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic                  busy,
    output logic                  overflow
);
    localparam int CW = NUM_CHAINS > 1 ? $clog2(NUM_CHAINS) : 1;
    localparam int BW = $clog2(WORD_W);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, DUMP, FLUSH, TRAIL, NEXT} state_t;

    state_t            state;
    logic [CW-1:0]     cidx;
    logic [BW-1:0]     wcnt;
    logic [WORD_W-1:0] acc;
    logic [15:0]       total;

    logic              sel_bit, sel_vld, sel_done, take, word_full;
    logic              push, push_last, pop, wr, full;
    logic [WORD_W-1:0] acc_next, trailer, push_data;

    logic [WORD_W:0]   mem [FIFO_DEPTH];
    logic [AW:0]       wptr, rptr;

    assign out_vld = wptr != rptr;
    assign full    = wptr == {~rptr[AW], rptr[AW-1:0]};
    assign pop     = out_vld && out_rdy;
    assign wr      = push && (!full || pop);
    assign {out_last, out_data} = out_vld ? mem[rptr[AW-1:0]] : '0;

    // Selected-chain decode and the word (data, flush or trailer) offered to the FIFO this cycle
    always_comb begin
        sel_bit        = ch_in[cidx];
        sel_vld        = ch_in_vld[cidx];
        sel_done       = ch_in_done[cidx];
        take           = state == DUMP && sel_vld;
        word_full      = take && wcnt == BW'(WORD_W - 1);
        acc_next       = acc;
        acc_next[wcnt] = sel_bit;
        trailer        = WORD_W'({8'(cidx), total});
        push           = word_full || (state == FLUSH && wcnt != '0) || state == TRAIL;
        push_last      = state == TRAIL;
        push_data      = push_last ? trailer : (state == FLUSH ? acc : acc_next);
    end

    // Dump sequencer: walks chains in order, assembles words and drives dump_en/busy
    always_ff @(posedge sh_clk) begin
        if (!sh_rst_l) begin
            state   <= IDLE;
            cidx    <= '0;
            wcnt    <= '0;
            acc     <= '0;
            total   <= '0;
            dump_en <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cidx    <= '0;
                    wcnt    <= '0;
                    acc     <= '0;
                    total   <= '0;
                    dump_en <= NUM_CHAINS'(1);
                    busy    <= 1'b1;
                    state   <= DUMP;
                end
                DUMP: begin
                    if (take) begin
                        wcnt  <= word_full ? '0 : wcnt + 1'b1;
                        acc   <= word_full ? '0 : acc_next;
                        total <= total + 16'(total != 16'hFFFF);
                    end
                    if (sel_done) begin
                        dump_en <= '0;
                        state   <= FLUSH;
                    end
                end
                FLUSH: state <= TRAIL;
                TRAIL: state <= NEXT;
                NEXT: if (cidx == CW'(NUM_CHAINS - 1)) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    cidx    <= cidx + 1'b1;
                    wcnt    <= '0;
                    acc     <= '0;
                    total   <= '0;
                    dump_en <= NUM_CHAINS'(1) << (cidx + 1'b1);
                    state   <= DUMP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output FIFO; a push that finds it full with no same-cycle pop is dropped and flagged
    always_ff @(posedge sh_clk) begin
        if (!sh_rst_l) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) begin
                mem[wptr[AW-1:0]] <= {push_last, push_data};
                wptr              <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            if (push && !wr) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_shadow_dump_collector.sv
// tb_shadow_dump_collector: randomized dumps scored against a per-chain word/trailer model
module tb_shadow_dump_collector;
    localparam int NC = 4;
    localparam int W  = 32;
    localparam int D  = 8;

    logic          sh_clk = 1'b0;
    logic          sh_rst_l = 1'b0;
    logic          start = 1'b0;
    logic          out_rdy = 1'b0;
    logic [NC-1:0] dump_en;
    logic [NC-1:0] ch_in = '0;
    logic [NC-1:0] ch_in_vld = '0;
    logic [NC-1:0] ch_in_done = '0;
    logic [W-1:0]  out_data;
    logic          out_last, out_vld, busy, overflow;

    int passed = 0;
    int total = 0;

    bit         chain_bits [NC][$];
    bit         together [NC];
    logic [W:0] exp_q [$];
    logic [W:0] got_q [$];

    shadow_dump_collector #(.NUM_CHAINS(NC), .WORD_W(W), .FIFO_DEPTH(D)) dut (
        .sh_clk(sh_clk), .sh_rst_l(sh_rst_l), .start(start), .dump_en(dump_en),
        .ch_in(ch_in), .ch_in_vld(ch_in_vld), .ch_in_done(ch_in_done),
        .out_data(out_data), .out_last(out_last), .out_vld(out_vld), .out_rdy(out_rdy),
        .busy(busy), .overflow(overflow)
    );

    always #5 sh_clk = ~sh_clk;

    // Expected stream: each chain chopped into W-bit words (last one zero-padded), then its trailer
    task automatic build_model();
        logic [W-1:0] w;
        int len;
        exp_q.delete();
        for (int c = 0; c < NC; c++) begin
            len = chain_bits[c].size();
            for (int s = 0; s < len; s += W) begin
                w = '0;
                for (int k = s; k < len && k < s + W; k++)
                    if (chain_bits[c][k]) w = w | (W'(1) << (k - s));
                exp_q.push_back({1'b0, w});
            end
            exp_q.push_back({1'b1, (W'(c) << 16) | W'(len > 65535 ? 65535 : len)});
        end
    endtask

    task automatic clear_chains();
        for (int c = 0; c < NC; c++) begin
            chain_bits[c].delete();
            together[c] = 1'b0;
        end
    endtask

    // Full dump acting as the capture side; rel<0 gives random out_rdy, else out_rdy=1 once chain 0 has sent rel bits
    task automatic run_dump(input int dens, input int rel, input int keep);
        int sent [NC];
        bit fin [NC];
        int nxt, gap, c, k;
        bit v, d, ended;
        logic [NC-1:0] exp_en;
        got_q.delete();
        for (int i = 0; i < NC; i++) begin
            sent[i] = 0;
            fin[i] = 1'b0;
        end
        nxt = 0;
        gap = 0;
        ended = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge sh_clk);
            if (cyc > 1 && !busy) begin
                ended = 1'b1;
                break;
            end
            if (cyc == 1) begin
                total++;
                if (busy !== 1'b1 || dump_en !== NC'(1))
                    $display("FAIL start_latency: busy=%b dump_en=%b, want busy=1 dump_en=%b", busy, dump_en, NC'(1));
                else passed++;
            end
            if (dump_en != '0) begin
                if (gap > 0) begin
                    exp_en = NC'(1) << nxt;
                    total++;
                    if (dump_en !== exp_en || (nxt > 0 && gap != 3))
                        $display("FAIL dump_en_step: dump_en=%b gap=%0d, want %b gap=3", dump_en, gap, exp_en);
                    else passed++;
                    nxt++;
                end
                gap = 0;
            end else gap++;
            ch_in      = NC'($urandom);
            ch_in_vld  = NC'($urandom);
            ch_in_done = NC'($urandom) & NC'($urandom) & NC'($urandom);
            start      = (cyc == 0) || (busy && $urandom_range(15) == 0);
            if ($countones(dump_en) == 1) begin
                c = 0;
                for (int i = 0; i < NC; i++) if (dump_en[i]) c = i;
                v = 1'b0;
                d = 1'b0;
                if (!fin[c]) begin
                    v = sent[c] < chain_bits[c].size() && $urandom_range(99) < dens;
                    if (v) begin
                        ch_in[c] = chain_bits[c][sent[c]];
                        sent[c]++;
                    end
                    d = sent[c] == chain_bits[c].size() && (!v || together[c]);
                    fin[c] = d;
                end
                ch_in_vld[c]  = v;
                ch_in_done[c] = d;
            end
            out_rdy = rel < 0 ? ($urandom_range(3) != 0) : (sent[0] >= rel);
            if (out_vld && out_rdy) got_q.push_back({out_last, out_data});
        end
        start      = 1'b0;
        ch_in_vld  = '0;
        ch_in_done = '0;
        out_rdy    = 1'b1;
        total++;
        if (!ended || nxt != NC)
            $display("FAIL dump_end: ended=%b chains=%0d, want ended=1 chains=%0d", ended, nxt, NC);
        else passed++;
        for (k = 0; k < 64; k++) begin
            if (!out_vld) break;
            got_q.push_back({out_last, out_data});
            @(negedge sh_clk);
        end
        out_rdy = 1'b0;
        total++;
        if (got_q.size() != keep)
            $display("FAIL word_count: got %0d words, want %0d", got_q.size(), keep);
        else passed++;
        for (int i = 0; i < keep && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL word[%0d]: got last=%b data=%h, want last=%b data=%h",
                         i, got_q[i][W], got_q[i][W-1:0], exp_q[i][W], exp_q[i][W-1:0]);
            else passed++;
        end
    endtask

    task automatic test_reset();
        sh_rst_l = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start      = 1'($urandom);
            out_rdy    = 1'($urandom);
            ch_in      = NC'($urandom);
            ch_in_vld  = NC'($urandom);
            ch_in_done = NC'($urandom);
            @(negedge sh_clk);
            total++;
            if ({dump_en, out_vld, out_last, out_data, busy, overflow} !== '0)
                $display("FAIL reset_outputs: dump_en=%b vld=%b last=%b data=%h busy=%b ovf=%b, want all 0",
                         dump_en, out_vld, out_last, out_data, busy, overflow);
            else passed++;
        end
        start = 1'b0;
        ch_in_vld = '0;
        ch_in_done = '0;
        out_rdy = 1'b0;
        sh_rst_l = 1'b1;
        @(negedge sh_clk);
        total++;
        if (busy !== 1'b0 || dump_en !== '0 || out_vld !== 1'b0)
            $display("FAIL reset_release: busy=%b dump_en=%b vld=%b, want 0", busy, dump_en, out_vld);
        else passed++;
    endtask

    task automatic test_directed();
        logic [63:0] pat;
        logic [W-1:0] w3;
        logic [W:0] want [8];
        pat = 64'hDEADBEEF_01234567;
        clear_chains();
        for (int k = 0; k < 64; k++) chain_bits[0].push_back(pat[k]);
        together[0] = 1'($urandom);
        chain_bits[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        w3 = W'($urandom);
        for (int k = 0; k < W; k++) chain_bits[3].push_back(w3[k]);
        together[3] = 1'b1;
        build_model();
        run_dump(80, -1, exp_q.size());
        want = '{{1'b0, 32'h01234567}, {1'b0, 32'hDEADBEEF}, {1'b1, 32'h00000040}, {1'b1, 32'h00010000},
                 {1'b0, 32'h0000001D}, {1'b1, 32'h00020005}, {1'b0, w3}, {1'b1, 32'h00030020}};
        total++;
        if (got_q.size() != 8) $display("FAIL directed_count: got %0d words, want 8", got_q.size());
        else passed++;
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== want[i])
                $display("FAIL directed[%0d]: got %h, want %h", i, got_q[i], want[i]);
            else passed++;
        end
    endtask

    task automatic test_multi_chain();
        clear_chains();
        for (int c = 0; c < NC; c++) begin
            for (int k = 0; k < 8 * (c + 1); k++) chain_bits[c].push_back(1'($urandom));
            together[c] = 1'($urandom);
        end
        build_model();
        run_dump(60, -1, exp_q.size());
        total++;
        if (busy !== 1'b0) $display("FAIL multi_busy: busy=%b, want 0", busy);
        else passed++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            clear_chains();
            for (int c = 0; c < NC; c++) begin
                for (int k = 0; k < int'($urandom_range(120)); k++) chain_bits[c].push_back(1'($urandom));
                together[c] = 1'($urandom);
            end
            build_model();
            run_dump(int'($urandom_range(100, 30)), -1, exp_q.size());
            total++;
            if (overflow !== 1'b0) $display("FAIL random_overflow: overflow=%b, want 0", overflow);
            else passed++;
        end
    endtask

    task automatic test_overflow();
        clear_chains();
        for (int k = 0; k < 10 * W; k++) chain_bits[0].push_back(1'($urandom));
        build_model();
        run_dump(100, 1 << 30, D);
        total++;
        if (overflow !== 1'b1) $display("FAIL overflow_sticky: overflow=%b, want 1", overflow);
        else passed++;
    endtask

    task automatic test_reset_mid_dump();
        @(negedge sh_clk);
        start = 1'b1;
        @(negedge sh_clk);
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            ch_in_vld = NC'(1);
            ch_in = NC'($urandom);
            @(negedge sh_clk);
        end
        total++;
        if (out_vld !== 1'b1 || dump_en !== NC'(1))
            $display("FAIL mid_dump_state: vld=%b dump_en=%b, want vld=1 dump_en=%b", out_vld, dump_en, NC'(1));
        else passed++;
        sh_rst_l = 1'b0;
        ch_in_vld = '0;
        @(negedge sh_clk);
        total++;
        if (dump_en !== '0 || out_vld !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || out_data !== '0)
            $display("FAIL mid_dump_reset: dump_en=%b vld=%b busy=%b ovf=%b data=%h, want all 0",
                     dump_en, out_vld, busy, overflow, out_data);
        else passed++;
        sh_rst_l = 1'b1;
        @(negedge sh_clk);
        total++;
        if (busy !== 1'b0 || out_vld !== 1'b0)
            $display("FAIL mid_dump_release: busy=%b vld=%b, want 0", busy, out_vld);
        else passed++;
    endtask

    task automatic test_push_pop_full();
        clear_chains();
        for (int k = 0; k < 9 * W; k++) chain_bits[0].push_back(1'($urandom));
        together[0] = 1'($urandom);
        build_model();
        run_dump(100, 9 * W, exp_q.size());
        total++;
        if (overflow !== 1'b0) $display("FAIL push_pop_full: overflow=%b, want 0", overflow);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_multi_chain();
        test_random();
        test_overflow();
        test_reset_mid_dump();
        test_push_pop_full();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/shadow_dump_collector.md
# shadow_dump_collector

Receiving end of the shadow-capture chain dump interface. Sequences `dump_en` across `NUM_CHAINS` shadow capture instances one chain at a time, deserializes each chain's serial bit stream (`ch_out`/`ch_out_vld`/`ch_out_done` from the capture side) into `WORD_W`-bit words, and queues them with a per-chain trailer word in an output FIFO for the debug host readout path. Runs entirely in the shadow clock domain.

## Interface
- `NUM_CHAINS`, 4: number of capture chains serviced; each is dumped in index order, 0 first.
- `WORD_W`, 32: output word width; must be at least 24.
- `FIFO_DEPTH`, 8: output FIFO entries; power of two, at least 2.
- `sh_clk`  in  1  shadow/data clock; all logic is on the rising edge.
- `sh_rst_l`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request to begin a full dump; sampled only in IDLE.
- `dump_en`  out  NUM_CHAINS  one-hot dump enable to capture instances; bit i goes to chain i.
- `ch_in`  in  NUM_CHAINS  serial data from each chain's `ch_out`.
- `ch_in_vld`  in  NUM_CHAINS  bit valid from each chain's `ch_out_vld`.
- `ch_in_done`  in  NUM_CHAINS  end-of-chain from each chain's `ch_out_done`.
- `out_data`  out  WORD_W  FIFO head word.
- `out_last`  out  1  head word is a chain trailer.
- `out_vld`  out  1  FIFO non-empty.
- `out_rdy`  in  1  consumer accepts head when `out_vld && out_rdy`.
- `busy`  out  1  high in any state other than IDLE.
- `overflow`  out  1  sticky: a word was dropped because the FIFO was full.

## Operation
- States: IDLE, DUMP, FLUSH, TRAIL, NEXT. Chain index register `cidx`.
- IDLE: `start`=1 → `cidx`=0, clear bit counters, → DUMP. `start` outside IDLE ignored.
- DUMP: `dump_en` = one-hot(`cidx`). Bit accepted when `ch_in_vld[cidx]`; shifted LSB-first into the word assembler (first bit received → `out_data[0]`). `ch_in`/`ch_in_vld`/`ch_in_done` of non-selected chains ignored.
- Word assembler count reaches `WORD_W` → push word (`out_last`=0), count restarts at 0 in the same cycle.
- Chain bit total: 16-bit counter, increments per accepted bit, saturates at 0xFFFF.
- `ch_in_done[cidx]`=1 → → FLUSH; a bit with `vld` in the same cycle is accepted first and counted.
- FLUSH: partial count > 0 → push word zero-padded in upper bits; count = 0 → no push. → TRAIL.
- TRAIL: push trailer with `out_last`=1: [15:0] = chain bit total, [23:16] = `cidx`, upper bits zero. → NEXT.
- NEXT: `cidx` = NUM_CHAINS−1 → IDLE; else `cidx`+1, clear counters, → DUMP.
- Push with FIFO full (and no same-cycle pop) → word dropped, `overflow` set; the state machine never stalls, since the capture side cannot be back-pressured. Push and pop in the same cycle with the FIFO full → allowed, no drop.
- `overflow` is cleared only by reset.

## Timing
- Reset values: `dump_en`=0, `out_vld`=0, `out_last`=0, `out_data`=0, `busy`=0, `overflow`=0; FIFO empty; state IDLE.
- `start` at cycle N → `busy`=1 and `dump_en[0]`=1 at N+1.
- A word is pushed in the cycle its final bit is accepted, or in the cycle FLUSH/TRAIL is occupied. It is visible at `out_vld`/`out_data` at the next cycle if the FIFO was empty.
- `dump_en` drops in the first FLUSH cycle, one cycle after `ch_in_done` is sampled.
- Per chain: DUMP → FLUSH → TRAIL → NEXT. `dump_en` for the next chain asserts in the cycle after NEXT, so there are 3 cycles with all `dump_en` low between chains.
- Last NEXT → IDLE; `busy`=0 in the following cycle. The FIFO may still hold data.
- `sh_rst_l`=0 mid-dump → next edge: all state cleared, FIFO flushed, `dump_en`=0.

## Test plan
- Reset: hold `sh_rst_l`=0 with random inputs → all outputs 0; deassert → IDLE, `busy`=0.
- Single chain, NUM_CHAINS=1, 64 bits of pattern 0xDEADBEEF_01234567 (LSB-first, low word first) → words 0x01234567, 0xDEADBEEF, then trailer 0x00000040 with `out_last`=1; no partial word.
- Partial flush: chain 2 sends 5 bits 1,0,1,1,1 then done → word 0x0000001D, then trailer 0x00020005.
- Multi-chain sequencing, NUM_CHAINS=4, chain i sends 8·(i+1) bits → `dump_en` steps 0001→0010→0100→1000 with 3 idle cycles between; 4 trailers with [23:16] = 0..3 in order; `busy` falls after the 4th.
- Overflow: `out_rdy`=0, FIFO_DEPTH=8, stream 10 full words → 8 words retained, `overflow`=1 and remains 1 after draining; push/pop on the same cycle at full → no drop.
- Corner cases: `vld` and `done` asserted together on the 32nd bit → one full word plus trailer, no empty partial; reset mid-DUMP → FIFO empty, `dump_en`=0; `start` while busy → ignored; `vld` on non-selected chains → ignored.
